regfile_8x16: RTL
=================

Name: regfile_8x16

Overview:
- 8-entry x 16-bit general-purpose register file for the 16-bit CPU datapath.
- One write port and two asynchronous read ports.
- The write-enable is fanned out to per-register load enables by a 1-to-8 demux tree.
- Sits directly downstream of the write-enable demux stage, between writeback and the ALU operand muxes.

Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers (power of two)
- ADDR_W, 3, log2(NREGS)
- ZERO_R0, 1, 1 = R0 reads as 0 and ignores writes; 0 = R0 is an ordinary register
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data; 0 = returns the stored (old) value

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe for the current cycle
- wr_addr  in  ADDR_W  destination register index
- wr_data  in  DATA_W  writeback data
- rd_addr_a  in  ADDR_W  read port A index
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- wr_ack  out  1  registered pulse, high the cycle after an accepted write
- last_wr_addr  out  ADDR_W  index of the most recent accepted write (registered)

Behaviour:
- Reset (async, rst=1): all registers -> 16'h0000; wr_ack -> 0; last_wr_addr -> 0. Asserting reset mid-write discards the pending write. No write is accepted while rst=1.
- Write decode: wr_en passes through a 1-to-8 demux selected by wr_addr. Exactly one load enable is high when wr_en=1; none when wr_en=0.
- Write latency: a register updates on the rising edge where its load enable is high; the new value is visible from the next cycle.
- Accepted write: wr_en=1 and NOT (ZERO_R0=1 and wr_addr=0).
  - Effect 1: wr_ack=1 the following cycle, for exactly one cycle.
  - Effect 2: last_wr_addr is updated to wr_addr.
  - A rejected R0 write leaves wr_ack=0 and last_wr_addr unchanged.
- Back-to-back writes: accepted every cycle; wr_ack stays high for consecutive accepted writes.
- Reads are combinational from rd_addr_*: zero latency, no handshake.
- R0 rule: with ZERO_R0=1, rd_data for index 0 is always 0, regardless of any bypass.
- Bypass (BYPASS=1): if wr_en=1 and rd_addr_x==wr_addr (and not the R0 case), rd_data_x=wr_data in the same cycle.
  - Both ports may bypass simultaneously.
  - Same-address reads on A and B return identical data.
- BYPASS=0: same-cycle reads return the pre-edge value.
- Widths: no arithmetic. Indices wider than ADDR_W are not possible by construction.
- No X propagation: outputs are defined from the first reset onward.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=16, NREGS=8, ADDR_W=3
  - typedef word_t (logic [15:0]), typedef reg_idx_t (logic [2:0])
  - REG_ZERO=3'd0
- Natural sub-module: dmux_1to8 (wr_en, wr_addr -> 8 load enables), built as a tree of 1-to-2 demuxes.
- Read muxes stay inline.

Test Plan:
1. Reset, then read all 8 indices on both ports -> every rd_data = 16'h0000; wr_ack=0; last_wr_addr=0.
2. Write R3=16'hBEEF, then next cycle read A=3, B=3 -> both 16'hBEEF; wr_ack=1 that cycle only; last_wr_addr=3. All other registers stay 0.
3. Write R0=16'h1234 with ZERO_R0=1 -> rd_data_a(0)=0 in the same cycle and afterwards; wr_ack stays 0; last_wr_addr unchanged.
4. Bypass, BYPASS=1: R5 holds 16'h0001; write R5=16'h00FF while rd_addr_a=5 -> rd_data_a=16'h00FF the same cycle. With BYPASS=0 -> 16'h0001 the same cycle, then 16'h00FF the next cycle.
5. Back-to-back writes R1=16'h0011, R2=16'h0022, R7=16'hFFFF on consecutive cycles -> wr_ack high 3 consecutive cycles; final reads R1/R2/R7 return those values; last_wr_addr=7.
6. Assert rst asynchronously mid-cycle with wr_en=1, R4=16'hAAAA -> all outputs immediately 0; after release R4=16'h0000 and wr_ack=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants for the register file slice.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 3'd0;

    // Elementary 1-to-2 demux: bit 1 carries en when sel=1, bit 0 when sel=0.
    function automatic logic [1:0] demux2(input logic en, input logic sel);
        return {en & sel, en & ~sel};
    endfunction

endpackage

// File: rtl/regfile_8x16_dmux.sv
// 1-to-8 write-enable demux built as a three-level tree of 1-to-2 demuxes.
module dmux_1to8
    import cpu_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREGS-1:0]  ld
);

    logic [1:0] lvl1;
    logic [3:0] lvl2;

    // Levels are split MSB first, so ld index equals addr.
    assign lvl1 = demux2(en, addr[2]);

    for (genvar i = 0; i < 2; i++) begin : g_lvl2
        assign lvl2[2*i +: 2] = demux2(lvl1[i], addr[1]);
    end

    for (genvar i = 0; i < 4; i++) begin : g_lvl3
        assign ld[2*i +: 2] = demux2(lvl2[i], addr[0]);
    end

endmodule

// File: rtl/regfile_8x16.sv
// 8x16 register file: one write port, two combinational read ports, optional hard-zero R0 and write bypass.
module regfile_8x16
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] last_wr_addr
);

    localparam bit R0_HARD = (ZERO_R0 != 0);
    localparam bit BYP_ON  = (BYPASS != 0);

    logic [NREGS-1:0]  ld;
    logic              accept;
    logic [DATA_W-1:0] regs [NREGS];

    assign accept = wr_en && !(R0_HARD && (wr_addr == REG_ZERO));

    dmux_1to8 u_dmux (
        .en   (wr_en),
        .addr (wr_addr),
        .ld   (ld)
    );

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam bit KEEP_ZERO = R0_HARD && (i == 0);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (ld[i] && !KEEP_ZERO) begin
                regs[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack       <= 1'b0;
            last_wr_addr <= '0;
        end else begin
            wr_ack <= accept;
            if (accept) begin
                last_wr_addr <= wr_addr;
            end
        end
    end

    // R0 forcing has priority over bypass; bypass is suppressed while reset is held.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              byp_en,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (BYP_ON && byp_en && (ra == waddr)) begin
            val = wdata;
        end
        if (R0_HARD && (ra == REG_ZERO)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a, regs[rd_addr_a], wr_en && !rst, wr_addr, wr_data);
        rd_data_b = read_port(rd_addr_b, regs[rd_addr_b], wr_en && !rst, wr_addr, wr_data);
    end

endmodule
